btb_update_ctrl: RTL and testbench
==================================

BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

Interface
REQ-001 SHALL have parameter SET_ADDR_LEN, default 7, meaning the BTB index width (2^SET_ADDR_LEN sets).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of pending update slots (power of two, at least 2).
REQ-003 SHALL have port clk, input, width 1, the single clock.
REQ-004 SHALL have port rst_n, input, width 1, the asynchronous active-low reset.
REQ-005 SHALL have port ex_upd_valid, input, width 1, meaning the EX stage resolved a taken branch that must be installed.
REQ-006 SHALL have port PC_EX, input, width 32, the branch PC.
REQ-007 SHALL have port PC_Branch, input, width 32, the resolved target.
REQ-008 SHALL have port ex_upd_ready, output, width 1, asserted when the FIFO is not full and no sweep is active.
REQ-009 SHALL have port flush_req, input, width 1, a single-cycle request to invalidate the whole BTB.
REQ-010 SHALL have port btb_wr_req, output, width 1, the BTB write strobe.
REQ-011 SHALL have port btb_wr_pc, output, width 32, the PC whose set field selects the entry.
REQ-012 SHALL have port btb_wr_target, output, width 32, the target to store.
REQ-013 SHALL have port btb_wr_valid, output, width 1: 1 installs the entry, 0 invalidates it.
REQ-014 SHALL have port sweep_busy, output, width 1, high while the invalidation sweep runs.
REQ-015 SHALL have port sweep_done, output, width 1, a one-cycle pulse when the sweep completes.
REQ-016 SHALL have port overflow, output, width 1, a sticky flag: an update was dropped.

Function
REQ-017 SHALL implement FSM states IDLE and SWEEP; IDLE->SWEEP on flush_req; SWEEP->IDLE after the write to the last set.
REQ-018 SHALL enqueue {PC_EX, PC_Branch} at a clock edge when ex_upd_valid && ex_upd_ready.
REQ-019 SHALL, when ex_upd_valid is high and ex_upd_ready is low, drop the event and set overflow.
REQ-020 SHALL, in IDLE with the FIFO non-empty, drive btb_wr_req=1, btb_wr_valid=1 and the head entry combinationally, and pop the head at the same edge.
REQ-021 SHALL allow an enqueue and a dequeue at the same edge; occupancy is unchanged and pointers wrap modulo FIFO_DEPTH.
REQ-022 SHALL give one-cycle latency: an event enqueued at edge N appears on btb_wr_req in cycle N+1 if the FIFO was empty.
REQ-023 SHALL write in sweep order: for each index i from 0 to 2^SET_ADDR_LEN-1, one per cycle, btb_wr_req=1, btb_wr_valid=0, btb_wr_pc={0, i, 2'b00}, btb_wr_target=0.
REQ-024 SHALL, on flush_req, clear the FIFO at that edge (pending updates discarded), and any simultaneous ex_upd_valid is dropped without setting overflow.
REQ-025 SHALL, on flush_req during SWEEP, restart the sweep from index 0.
REQ-026 SHALL pulse sweep_done in the cycle after the final sweep write, with sweep_busy already low.
REQ-027 SHALL clear overflow only by reset or flush_req.
REQ-028 SHALL drive btb_wr_pc, btb_wr_target and btb_wr_valid to 0 whenever btb_wr_req=0.

Reset
REQ-029 SHALL, on rst_n low, asynchronously force: IDLE, FIFO empty, sweep index 0, btb_wr_req=0, sweep_busy=0, sweep_done=0, overflow=0 and ex_upd_ready=1; reset mid-sweep abandons the sweep.

Configuration
REQ-030 SHALL, with macro BTB_CTRL_PERF_EN defined, add outputs upd_cnt[31:0] (installs written) and drop_cnt[31:0] (overflow drops); both reset to 0, saturate at all-ones, and are unaffected by flush.
REQ-031 SHALL, without BTB_CTRL_PERF_EN, omit both ports and their counters.

Structure
REQ-032 SHALL place in package btb_pkg: the SET_ADDR_LEN default, typedef btb_upd_t {pc[31:0], target[31:0]}, and the FSM state enum.
REQ-033 SHALL implement the queue as sub-module btb_upd_fifo (push, pop, clear, full, empty).

Verification
REQ-034 SHALL verify: a single update with PC_EX=0x0000_0104 and PC_Branch=0x0000_0200 -> btb_wr_req one cycle later with btb_wr_pc=0x104, target 0x200 and valid=1.
REQ-035 SHALL verify: 6 back-to-back updates with FIFO_DEPTH=4 -> all 6 written in order, overflow stays 0.
REQ-036 SHALL verify: flush_req with 3 pending updates -> 128 invalidate writes at indices 0..127, no installs, sweep_done at cycle 129.
REQ-037 SHALL verify: ex_upd_valid during the sweep -> event dropped and overflow=1 (drop_cnt=1 when BTB_CTRL_PERF_EN is defined).
REQ-038 SHALL verify: rst_n low at sweep index 50 -> all outputs are at reset values immediately, and there is no further write.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types and defaults for the BTB update controller.
package btb_pkg;

    // Default BTB index width: 2^7 = 128 sets.
    localparam int SET_ADDR_LEN_DEF = 7;

    // One pending BTB install: branch PC and its resolved target.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
    } btb_upd_t;

    // Controller modes: draining updates, or invalidating every set.
    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// Small update queue. The head is read combinationally so the controller can
// present it on the BTB write port in the same cycle it is popped.
// clear empties the queue at the edge and takes priority over push/pop.
module btb_upd_fifo
    import btb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  logic     pop,
    input  logic     clear,
    input  btb_upd_t din,
    output btb_upd_t dout,
    output logic     full,
    output logic     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

    btb_upd_t        mem [DEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [PW:0]     count_reg;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count_reg == DEPTH_C);
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full && !clear;
    assign pop_ok  = pop && !empty && !clear;
    assign dout    = mem[rd_ptr_reg];

    // Storage write; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop_ok};
        end
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB update controller: queues resolved taken branches from EX and writes
// them into the BTB one per cycle, or sweeps every set invalid on flush.
// Optional macro BTB_CTRL_PERF_EN adds saturating upd_cnt/drop_cnt outputs.
module btb_update_ctrl
    import btb_pkg::*;
#(
    parameter int SET_ADDR_LEN = SET_ADDR_LEN_DEF,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_upd_valid,
    input  logic [31:0] PC_EX,
    input  logic [31:0] PC_Branch,
    output logic        ex_upd_ready,
    input  logic        flush_req,
    output logic        btb_wr_req,
    output logic [31:0] btb_wr_pc,
    output logic [31:0] btb_wr_target,
    output logic        btb_wr_valid,
    output logic        sweep_busy,
    output logic        sweep_done,
    output logic        overflow
`ifdef BTB_CTRL_PERF_EN
    ,
    output logic [31:0] upd_cnt,
    output logic [31:0] drop_cnt
`endif
);

    localparam logic [SET_ADDR_LEN-1:0] LAST_IDX = '1;

    ctrl_state_t             state_reg, state_next;
    logic [SET_ADDR_LEN-1:0] idx_reg, idx_next;
    logic                    done_reg, done_next;
    logic                    overflow_reg;

    btb_upd_t fifo_din;
    btb_upd_t fifo_head;
    logic     fifo_full;
    logic     fifo_empty;
    logic     fifo_push;
    logic     fifo_pop;
    logic     drop;

    assign fifo_din     = '{pc: PC_EX, target: PC_Branch};
    assign ex_upd_ready = !fifo_full && (state_reg == IDLE);
    // An update arriving with a flush is discarded silently along with the queue.
    assign fifo_push    = ex_upd_valid && ex_upd_ready && !flush_req;
    assign drop         = ex_upd_valid && !ex_upd_ready && !flush_req;
    assign sweep_busy   = (state_reg == SWEEP);
    assign sweep_done   = done_reg;
    assign overflow     = overflow_reg;

    btb_upd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (flush_req),
        .din   (fifo_din),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next state and BTB write port: installs from the queue head in IDLE,
    // invalidates one set per cycle in SWEEP. A flush in IDLE suppresses the
    // install so that nothing pending reaches the BTB once flush is seen.
    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        done_next     = 1'b0;
        fifo_pop      = 1'b0;
        btb_wr_req    = 1'b0;
        btb_wr_valid  = 1'b0;
        btb_wr_pc     = '0;
        btb_wr_target = '0;
        case (state_reg)
            IDLE: begin
                if (flush_req) begin
                    state_next = SWEEP;
                    idx_next   = '0;
                end else if (!fifo_empty) begin
                    btb_wr_req    = 1'b1;
                    btb_wr_valid  = 1'b1;
                    btb_wr_pc     = fifo_head.pc;
                    btb_wr_target = fifo_head.target;
                    fifo_pop      = 1'b1;
                end
            end
            SWEEP: begin
                btb_wr_req = 1'b1;
                btb_wr_pc  = {{(30 - SET_ADDR_LEN){1'b0}}, idx_reg, 2'b00};
                if (flush_req) begin
                    idx_next = '0;
                end else if (idx_reg == LAST_IDX) begin
                    state_next = IDLE;
                    idx_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Mode, sweep index and completion pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            done_reg  <= done_next;
        end
    end

    // Sticky drop flag, cleared only by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
        end else if (flush_req) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end
    end

`ifdef BTB_CTRL_PERF_EN
    logic [31:0] upd_cnt_reg;
    logic [31:0] drop_cnt_reg;

    assign upd_cnt  = upd_cnt_reg;
    assign drop_cnt = drop_cnt_reg;

    // Saturating event counters; flush does not touch them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_cnt_reg  <= '0;
            drop_cnt_reg <= '0;
        end else begin
            if (btb_wr_req && btb_wr_valid && !(&upd_cnt_reg)) begin
                upd_cnt_reg <= upd_cnt_reg + 1'b1;
            end
            if (drop && !(&drop_cnt_reg)) begin
                drop_cnt_reg <= drop_cnt_reg + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Randomized self-checking bench for btb_update_ctrl with a queue-based
// reference model. Define BTB_CTRL_PERF_EN to also check the counters.
module tb_btb_update_ctrl;

    localparam int NSETS = 128;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        ex_upd_valid;
    logic [31:0] PC_EX;
    logic [31:0] PC_Branch;
    logic        ex_upd_ready;
    logic        flush_req;
    logic        btb_wr_req;
    logic [31:0] btb_wr_pc;
    logic [31:0] btb_wr_target;
    logic        btb_wr_valid;
    logic        sweep_busy;
    logic        sweep_done;
    logic        overflow;
`ifdef BTB_CTRL_PERF_EN
    logic [31:0] upd_cnt;
    logic [31:0] drop_cnt;
`endif

    btb_update_ctrl #(
        .SET_ADDR_LEN (7),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_upd_valid  (ex_upd_valid),
        .PC_EX         (PC_EX),
        .PC_Branch     (PC_Branch),
        .ex_upd_ready  (ex_upd_ready),
        .flush_req     (flush_req),
        .btb_wr_req    (btb_wr_req),
        .btb_wr_pc     (btb_wr_pc),
        .btb_wr_target (btb_wr_target),
        .btb_wr_valid  (btb_wr_valid),
        .sweep_busy    (sweep_busy),
        .sweep_done    (sweep_done),
        .overflow      (overflow)
`ifdef BTB_CTRL_PERF_EN
        ,
        .upd_cnt       (upd_cnt),
        .drop_cnt      (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending updates as a queue, sweep position (-1 = none).
    logic [63:0] mq[$];
    int          spos;
    bit          movf;
    bit          mdone;
    longint      mupd;
    longint      mdrop;

    // Observation bookkeeping for directed scenarios.
    int          cyc;
    int          inv_seen;
    int          inst_seen;
    int          done_cyc;
    logic [63:0] obs_log[$];
    logic        obs_req;
    logic        obs_valid;
    logic [31:0] obs_pc;
    logic [31:0] obs_tgt;
    logic        obs_ovf;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        spos  = -1;
        movf  = 1'b0;
        mdone = 1'b0;
        mupd  = 0;
        mdrop = 0;
    endfunction

    // One clock cycle: drive inputs, compare outputs with the model, advance model.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] tg, input logic fl);
        logic        e_ready, e_req, e_valid;
        logic [31:0] e_pc, e_tgt;
        @(negedge clk);
        ex_upd_valid = v;
        PC_EX        = pc;
        PC_Branch    = tg;
        flush_req    = fl;
        #1;
        e_ready = (spos < 0) && (mq.size() < DEPTH);
        e_req = 1'b0; e_valid = 1'b0; e_pc = '0; e_tgt = '0;
        if (spos >= 0) begin
            e_req = 1'b1;
            e_pc  = 32'(spos * 4);
        end else if (!fl && mq.size() > 0) begin
            e_req   = 1'b1;
            e_valid = 1'b1;
            e_pc    = mq[0][63:32];
            e_tgt   = mq[0][31:0];
        end
        check("ready",  64'(ex_upd_ready),  64'(e_ready));
        check("wr_req", 64'(btb_wr_req),    64'(e_req));
        check("wr_valid", 64'(btb_wr_valid), 64'(e_valid));
        check("wr_pc",  64'(btb_wr_pc),     64'(e_pc));
        check("wr_tgt", 64'(btb_wr_target), 64'(e_tgt));
        check("busy",   64'(sweep_busy),    64'(spos >= 0));
        check("done",   64'(sweep_done),    64'(mdone));
        check("ovf",    64'(overflow),      64'(movf));
`ifdef BTB_CTRL_PERF_EN
        check("upd_cnt",  64'(upd_cnt),  64'(mupd));
        check("drop_cnt", 64'(drop_cnt), 64'(mdrop));
`endif
        obs_req = btb_wr_req; obs_valid = btb_wr_valid;
        obs_pc = btb_wr_pc; obs_tgt = btb_wr_target; obs_ovf = overflow;
        if (btb_wr_req && btb_wr_valid) begin
            inst_seen++;
            obs_log.push_back({btb_wr_pc, btb_wr_target});
        end
        if (btb_wr_req && !btb_wr_valid) inv_seen++;
        if (sweep_done) done_cyc = cyc;
        @(posedge clk);
        // Model update at the edge.
        mdone = (spos == NSETS - 1) && !fl;
        if (fl) begin
            mq.delete();
            spos = 0;
            movf = 1'b0;
        end else if (spos >= 0) begin
            spos = (spos == NSETS - 1) ? -1 : spos + 1;
            if (v) begin movf = 1'b1; mdrop++; end
        end else begin
            if (mq.size() > 0) begin void'(mq.pop_front()); mupd++; end
            if (v && e_ready) mq.push_back({pc, tg});
            else if (v) begin movf = 1'b1; mdrop++; end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        logic [63:0] sent[$];
        int          flush_cyc;
        cyc = 0; inv_seen = 0; inst_seen = 0; done_cyc = -1;
        rst_n = 1'b0; ex_upd_valid = 1'b0; PC_EX = '0; PC_Branch = '0; flush_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(ex_upd_ready), 64'd1);
        check("rst_req",   64'(btb_wr_req),   64'd0);
        check("rst_busy",  64'(sweep_busy),   64'd0);
        check("rst_ovf",   64'(overflow),     64'd0);
        rst_n = 1'b1;

        // Single update appears one cycle later.
        step(1'b1, 32'h0000_0104, 32'h0000_0200, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0);
        check("single_req",   64'(obs_req),   64'd1);
        check("single_pc",    64'(obs_pc),    64'h104);
        check("single_tgt",   64'(obs_tgt),   64'h200);
        check("single_valid", 64'(obs_valid), 64'd1);
        $display("single update pc=%0h tgt=%0h", obs_pc, obs_tgt);

        // Six back-to-back updates, all written in order.
        obs_log.delete();
        for (int i = 0; i < 6; i++) begin
            logic [31:0] p, t;
            p = $urandom(); t = $urandom();
            sent.push_back({p, t});
            step(1'b1, p, t, 1'b0);
        end
        idle(3);
        check("b2b_count", 64'(obs_log.size()), 64'd6);
        for (int i = 0; i < 6 && i < obs_log.size(); i++) check("b2b_order", obs_log[i], sent[i]);
        check("b2b_ovf", 64'(obs_ovf), 64'd0);
        $display("back-to-back: %0d installs", obs_log.size());

        // Flush with updates pending: full sweep, no installs.
        for (int i = 0; i < 3; i++) step(1'b1, $urandom(), $urandom(), 1'b0);
        inv_seen = 0; inst_seen = 0; done_cyc = -1;
        flush_cyc = cyc;
        step(1'b1, 32'h1234_5678, 32'h9abc_def0, 1'b1);
        for (int i = 0; i < 135 && done_cyc < 0; i++) idle(1);
        check("sweep_inv",   64'(inv_seen),           64'd128);
        check("sweep_inst",  64'(inst_seen),          64'd0);
        check("sweep_done_cyc", 64'(done_cyc - flush_cyc), 64'd129);
        $display("flush sweep: %0d invalidates, done at +%0d", inv_seen, done_cyc - flush_cyc);

        // Update during sweep is dropped and flags overflow.
        step(1'b0, 32'h0, 32'h0, 1'b1);
        idle(5);
        step(1'b1, 32'h0000_0400, 32'h0000_0800, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0);
        check("drop_ovf", 64'(obs_ovf), 64'd1);
`ifdef BTB_CTRL_PERF_EN
        check("drop_cnt1", 64'(drop_cnt), 64'd1);
`endif
        idle(NSETS);
        $display("drop during sweep: overflow=%0d", obs_ovf);

        // Reset at sweep index 50 abandons the sweep.
        step(1'b0, 32'h0, 32'h0, 1'b1);
        idle(50);
        @(negedge clk);
        ex_upd_valid = 1'b0; flush_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req",   64'(btb_wr_req),   64'd0);
        check("mid_rst_pc",    64'(btb_wr_pc),    64'd0);
        check("mid_rst_busy",  64'(sweep_busy),   64'd0);
        check("mid_rst_done",  64'(sweep_done),   64'd0);
        check("mid_rst_ovf",   64'(overflow),     64'd0);
        check("mid_rst_ready", 64'(ex_upd_ready), 64'd1);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        inv_seen = 0; inst_seen = 0;
        idle(10);
        check("post_rst_writes", 64'(inv_seen + inst_seen), 64'd0);
        $display("reset mid-sweep: writes after reset=%0d", inv_seen + inst_seen);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 6, $urandom(), $urandom(), $urandom_range(0, 299) == 0);
        end
        $display("random phase complete");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
